// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port,
// with a registered write stage and a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  chk_busy1,
  output logic                  chk_busy2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic                  prio_q, prio_d;
  logic                  hs0, hs1;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  assign req0_ready = !(req1_valid && prio_q);
  assign req1_ready = !(req0_valid && !prio_q);

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

  assign win_addr = hs1 ? req1_addr : req0_addr;
  assign win_data = hs1 ? req1_data : req0_data;

  always_comb begin
    prio_d = prio_q;
    unique case (1'b1)
      hs0:     prio_d = 1'b1;
      hs1:     prio_d = 1'b0;
      default: prio_d = prio_q;
    endcase
  end

  // x0 writes are consumed but never reach the register file
  always_comb begin
    rf_wen_d   = (hs0 || hs1) && (win_addr != '0);
    rf_waddr_d = rf_wen_d ? win_addr : rf_waddr_q;
    rf_wdata_d = rf_wen_d ? win_data : rf_wdata_q;
  end

  // retire, then a newer issue re-sets, then flush wipes everything
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q)
      busy_d[rf_waddr_q] = 1'b0;
    if (iss_valid && (iss_addr != '0))
      busy_d[iss_addr] = 1'b1;
    if (flush)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      prio_q     <= prio_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: behavioural model checked every cycle,
// plus directed literal checks of the main scenarios.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          iss_valid, flush;
  logic [AW-1:0] iss_addr, chk_addr1, chk_addr2;
  logic          chk_busy1, chk_busy2;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: turn = requester that wins the next conflict; pend = set of
  // registers with an outstanding producer; m_* = the registered write.
  bit          m_turn = 1'b0;
  bit          m_wen = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit          pend [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_turn  = 1'b0;
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      foreach (pend[i]) pend[i] = 1'b0;
    end else begin : upd
      int w;
      w = -1;
      if (req0_valid && (!req1_valid || m_turn == 1'b0)) w = 0;
      else if (req1_valid) w = 1;
      if (m_wen) pend[m_waddr] = 1'b0;
      if (iss_valid && iss_addr != 0) pend[iss_addr] = 1'b1;
      if (flush) foreach (pend[i]) pend[i] = 1'b0;
      m_wen = 1'b0;
      if (w == 0) begin
        m_turn = 1'b1;
        if (req0_addr != 0) begin
          m_wen = 1'b1; m_waddr = req0_addr; m_wdata = req0_data;
        end
      end else if (w == 1) begin
        m_turn = 1'b0;
        if (req1_addr != 0) begin
          m_wen = 1'b1; m_waddr = req1_addr; m_wdata = req1_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rf_wen", 32'(rf_wen), 32'(m_wen));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("req0_ready", 32'(req0_ready), 32'(!req1_valid || m_turn == 1'b0));
    chk("req1_ready", 32'(req1_ready), 32'(!req0_valid || m_turn == 1'b1));
    chk("chk_busy1", 32'(chk_busy1), 32'(pend[chk_addr1]));
    chk("chk_busy2", 32'(chk_busy2), 32'(pend[chk_addr2]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    iss_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    iss_addr = '0; chk_addr1 = 5'd3; chk_addr2 = 5'd0;

    // reset with both requesting
    req0_valid = 1'b1; req0_addr = 5'd1;
    req1_valid = 1'b1; req1_addr = 5'd2;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_busy3", 32'(chk_busy1), 32'd0);
    chk("rst_busy0", 32'(chk_busy2), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd1);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    idle();
    rst_n = 1'b1;

    // single EXU write
    cyc();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1 chk("exu_rdy", 32'(req0_ready), 32'd1);
    cyc();
    idle();
    #1;
    chk("exu_wen", 32'(rf_wen), 32'd1);
    chk("exu_waddr", 32'(rf_waddr), 32'd5);
    chk("exu_wdata", rf_wdata, 32'hDEADBEEF);
    cyc();
    #1 chk("exu_wen_off", 32'(rf_wen), 32'd0);

    // x0 discard from LSU
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    #1 chk("x0_rdy", 32'(req1_ready), 32'd1);
    cyc();
    idle();
    #1;
    chk("x0_wen", 32'(rf_wen), 32'd0);
    chk("x0_waddr", 32'(rf_waddr), 32'd5);
    chk("x0_wdata", rf_wdata, 32'hDEADBEEF);

    // conflict: grants must alternate 0,1,0,1
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h111;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h222;
    #1;
    chk("cf0_rdy0", 32'(req0_ready), 32'd1);
    chk("cf0_rdy1", 32'(req1_ready), 32'd0);
    cyc();
    req0_addr = 5'd3; req0_data = 32'h333;
    #1;
    chk("cf1_waddr", 32'(rf_waddr), 32'd1);
    chk("cf1_rdy0", 32'(req0_ready), 32'd0);
    chk("cf1_rdy1", 32'(req1_ready), 32'd1);
    cyc();
    req1_addr = 5'd4; req1_data = 32'h444;
    #1;
    chk("cf2_waddr", 32'(rf_waddr), 32'd2);
    chk("cf2_rdy0", 32'(req0_ready), 32'd1);
    chk("cf2_rdy1", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    #1 chk("cf3_waddr", 32'(rf_waddr), 32'd3);
    cyc();
    idle();
    #1;
    chk("cf4_waddr", 32'(rf_waddr), 32'd4);
    chk("cf4_wdata", rf_wdata, 32'h444);

    // scoreboard lifecycle on x7
    chk_addr1 = 5'd7;
    iss_valid = 1'b1; iss_addr = 5'd7;
    cyc();
    idle();
    #1 chk("sb_c1", 32'(chk_busy1), 32'd1);
    cyc();
    cyc();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    cyc();
    idle();
    #1;
    chk("sb_c4_wen", 32'(rf_wen), 32'd1);
    chk("sb_c4_busy", 32'(chk_busy1), 32'd1);
    cyc();
    #1 chk("sb_c5_busy", 32'(chk_busy1), 32'd0);

    // re-issue x7 in the same cycle its write commits
    iss_valid = 1'b1; iss_addr = 5'd7;
    cyc();
    iss_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h78;
    cyc();
    req0_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd7;
    #1 chk("sb_hit_wen", 32'(rf_wen), 32'd1);
    cyc();
    idle();
    #1 chk("sb_setwins", 32'(chk_busy1), 32'd1);

    // flush with in-flight write and same-cycle issue
    iss_valid = 1'b1; iss_addr = 5'd3;
    cyc();
    iss_addr = 5'd9;
    cyc();
    iss_valid = 1'b0;
    chk_addr1 = 5'd3; chk_addr2 = 5'd9;
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hA5A5;
    #1;
    chk("fl_pre3", 32'(chk_busy1), 32'd1);
    chk("fl_pre9", 32'(chk_busy2), 32'd1);
    cyc();
    req0_valid = 1'b0;
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd4;
    #1 chk("fl_wen", 32'(rf_wen), 32'd1);
    cyc();
    idle();
    #1;
    chk("fl_busy3", 32'(chk_busy1), 32'd0);
    chk("fl_busy9", 32'(chk_busy2), 32'd0);
    chk_addr1 = 5'd4; chk_addr2 = 5'd7;
    #1;
    chk("fl_busy4", 32'(chk_busy1), 32'd0);
    chk("fl_busy7", 32'(chk_busy2), 32'd0);

    // asynchronous reset during an in-flight write
    cyc();
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'hC0DE;
    cyc();
    idle();
    #1 chk("ar_wen_pre", 32'(rf_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_wen", 32'(rf_wen), 32'd0);
    chk("ar_waddr", 32'(rf_waddr), 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
